aes_iter_core: RTL and testbench
================================

Name: aes_iter_core

Overview:
Iterative AES-128 engine, one round per clock. It is the responder side of the START/DONE cipher interface that our benches and host sequencers drive. It latches KEY/TEXTIN on START, runs the key schedule on the fly, and pulses DONE with TEXTOUT held stable until the next accepted START. It supports encryption (ENCDEC=0) and direct-inverse decryption (ENCDEC=1).

Parameters:
NR, 10, number of rounds (AES-128 only; other values unsupported)

Ports:
CLK  in  1  system clock, all logic on rising edge
nRST  in  1  synchronous active-low reset
ENCDEC  in  1  mode, sampled with START: 0 = encrypt, 1 = decrypt
START  in  1  request pulse; KEY, TEXTIN, ENCDEC valid only in this cycle
KEY  in  128  cipher key, byte 0 = KEY[127:120]
TEXTIN  in  128  plaintext (enc) or ciphertext (dec), same byte order
DONE  out  1  one-cycle completion pulse
TEXTOUT  out  128  result; valid from the DONE cycle until the next accepted START

Behaviour:
- Reset (nRST=0 at edge): FSM to IDLE; round counter, state, round-key, TEXTOUT all 0; DONE=0. Reset overrides START. A reset mid-operation aborts with no DONE.
- FSM states: IDLE, KEXP, ROUND.
- IDLE: START=1 is accepted.
  - ENCDEC=0: state <= TEXTIN^KEY, rk <= KEY, rnd <= 1, go to ROUND.
  - ENCDEC=1: state <= TEXTIN, rk <= KEY, rnd <= 1, go to KEXP.
- KEXP (decrypt only): rk <= next forward round key (rcon[rnd]) each cycle, for 10 cycles. On the 10th cycle, state <= state^rk10, rnd <= 9, go to ROUND.
- ROUND, encrypt:
  - Each cycle: SubBytes, ShiftRows, MixColumns (skipped when rnd=10), then AddRoundKey with the next round key computed combinationally from rk.
  - rnd increments. At rnd=10: DONE <= 1, TEXTOUT <= result, go to IDLE.
- ROUND, decrypt:
  - Each cycle: InvShiftRows, InvSubBytes, AddRoundKey with rk_prev, then InvMixColumns (skipped when rnd=0).
  - rk_prev comes from the inverse key schedule: w3' = w3^w2, w2' = w2^w1, w1' = w1^w0, w0' = w0^SubWord(RotWord(w3'))^rcon[rnd+1].
  - rnd decrements. At rnd=0: DONE pulse, TEXTOUT load, go to IDLE.
- Latency (START accepted at edge k):
  - encrypt: DONE high in the cycle after edge k+10;
  - decrypt: DONE high in the cycle after edge k+20.
- START while in KEXP/ROUND is ignored. No queueing, and the operation in flight is unaffected.
- DONE is high for exactly one cycle. The FSM is already IDLE in that cycle, so a START coinciding with DONE is accepted (back-to-back).
- TEXTOUT is unchanged by an accepted START and only updates at the next DONE.
- KEY/TEXTIN/ENCDEC are don't-care (may be X) outside the START cycle. No X may propagate into registers.
- State byte order: column-major, byte i = bits [127-8i -: 8].

Decomposition:
- Package aes_pkg:
  - state enum {IDLE, KEXP, ROUND};
  - rcon table 1..10 (01,02,04,08,10,20,40,80,1b,36);
  - xtime/gmul functions;
  - ShiftRows/InvShiftRows byte-index functions.
- Sub-module aes_sbox (8-bit in, INV select, 8-bit out):
  - GF(2^8) inversion shared between forward and inverse paths, with affine/inverse-affine around it;
  - instantiated 16x for data and 4x for the key schedule.

Test Plan:
1. ENCDEC=0, KEY=000102030405060708090a0b0c0d0e0f, TEXTIN=00112233445566778899aabbccddeeff, START one cycle -> DONE exactly 10 cycles later, TEXTOUT=69c4e0d86a7b0430d8cdb78070b4c55a.
2. ENCDEC=1, same KEY, TEXTIN=69c4e0d86a7b0430d8cdb78070b4c55a -> DONE 20 cycles later, TEXTOUT=00112233445566778899aabbccddeeff.
3. KEY/TEXTIN driven to X after the START cycle, plus a second START 5 cycles later -> single DONE at the original latency, result as in (1), TEXTOUT stable afterwards.
4. Key and plaintext all zero, encrypt -> TEXTOUT=66e94bd4ef8a2c3b884cfa59ca342b2e. Then START in the DONE cycle with decrypt of that value -> second DONE 20 cycles later, TEXTOUT=0.
5. nRST=0 for one cycle at round 5 of an encrypt -> DONE never asserts, TEXTOUT=0. A fresh START then yields the correct result at the normal latency.
6. START held high continuously for 30 cycles, encrypt vector (1) -> DONE every 11 cycles, TEXTOUT always 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 core.
// Byte i of a 128-bit state sits at bits [127-8i -: 8], column-major.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, KEXP, ROUND} fsm_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Source byte for output byte i: index is {column, row}, rows rotate columns.
    function automatic logic [3:0] sr_idx(input logic [3:0] i);
        logic [1:0] c;
        c = i[3:2] + i[1:0];
        return {c, i[1:0]};
    endfunction

    function automatic logic [3:0] isr_idx(input logic [3:0] i);
        logic [1:0] c;
        c = i[3:2] - i[1:0];
        return {c, i[1:0]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box / inverse S-box sharing one GF(2^8) inverter (x^254).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_din,
    input  logic       i_inv,
    output logic [7:0] o_dout
);

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        a252 = gmul(a240, a12);
        return gmul(a252, a2);
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_inv;

    assign w_pre  = i_inv ? (rotl(i_din, 1) ^ rotl(i_din, 3) ^ rotl(i_din, 6) ^ 8'h05) : i_din;
    assign w_inv  = gf_inv(w_pre);
    assign o_dout = i_inv ? w_inv
                          : (w_inv ^ rotl(w_inv, 1) ^ rotl(w_inv, 2) ^ rotl(w_inv, 3)
                             ^ rotl(w_inv, 4) ^ 8'h63);

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128, one round per clock; decrypt first walks the key schedule
// forward to round key 10 and then unwinds it alongside the inverse rounds.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         ENCDEC,
    input  logic         START,
    input  logic [127:0] KEY,
    input  logic [127:0] TEXTIN,
    output logic         DONE,
    output logic [127:0] TEXTOUT
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    fsm_t         r_fsm;
    logic         r_mode;
    logic [3:0]   r_rnd;
    logic [127:0] r_state;
    logic [127:0] r_rk;

    logic         w_dec_rnd;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_ks_word, w_rot, w_subw, w_t;
    logic [7:0]   w_rc;
    logic [127:0] w_rk_fwd, w_rk_inv;
    logic [127:0] w_sb, w_perm, w_mix, w_imix, w_ark, w_enc, w_dec;

    // Key schedule: one shared SubWord serves forward expansion and its inverse.
    assign w_dec_rnd = (r_fsm == ROUND) && r_mode;
    assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
    assign w_ks_word = w_dec_rnd ? (w_w3 ^ w_w2) : w_w3;
    assign w_rot     = {w_ks_word[23:0], w_ks_word[31:24]};
    assign w_rc      = rcon(w_dec_rnd ? (r_rnd + 4'd1) : r_rnd);
    assign w_t       = w_subw ^ {w_rc, 24'h000000};

    for (genvar g = 0; g < 4; g++) begin : g_ksbox
        aes_sbox u_sbox (
            .i_din  (w_rot[31-8*g -: 8]),
            .i_inv  (1'b0),
            .o_dout (w_subw[31-8*g -: 8])
        );
    end

    always_comb begin
        w_rk_fwd[127:96] = w_w0 ^ w_t;
        w_rk_fwd[95:64]  = w_w1 ^ w_rk_fwd[127:96];
        w_rk_fwd[63:32]  = w_w2 ^ w_rk_fwd[95:64];
        w_rk_fwd[31:0]   = w_w3 ^ w_rk_fwd[63:32];
        w_rk_inv         = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
    end

    for (genvar g = 0; g < 16; g++) begin : g_dsbox
        aes_sbox u_sbox (
            .i_din  (r_state[127-8*g -: 8]),
            .i_inv  (r_mode),
            .o_dout (w_sb[127-8*g -: 8])
        );
    end

    // SubBytes and ShiftRows commute, so the byte permutation follows the S-boxes.
    always_comb begin
        w_perm = '0;
        w_mix  = '0;
        w_imix = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_mode) w_perm[127-8*i -: 8] = w_sb[127-8*int'(isr_idx(4'(i))) -: 8];
            else        w_perm[127-8*i -: 8] = w_sb[127-8*int'(sr_idx(4'(i))) -: 8];
        end
        w_ark = w_perm ^ w_rk_inv;
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32]  = mixcol(w_perm[127-32*c -: 32]);
            w_imix[127-32*c -: 32] = inv_mixcol(w_ark[127-32*c -: 32]);
        end
        w_enc = ((r_rnd == LAST_RND) ? w_perm : w_mix) ^ w_rk_fwd;
        w_dec = (r_rnd == 4'd0) ? w_ark : w_imix;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_fsm   <= IDLE;
            r_mode  <= 1'b0;
            r_rnd   <= 4'd0;
            r_state <= '0;
            r_rk    <= '0;
            DONE    <= 1'b0;
            TEXTOUT <= '0;
        end else begin
            DONE <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (START) begin
                        r_mode <= ENCDEC;
                        r_rk   <= KEY;
                        r_rnd  <= 4'd1;
                        if (ENCDEC) begin
                            r_state <= TEXTIN;
                            r_fsm   <= KEXP;
                        end else begin
                            r_state <= TEXTIN ^ KEY;
                            r_fsm   <= ROUND;
                        end
                    end
                end
                KEXP: begin
                    r_rk <= w_rk_fwd;
                    if (r_rnd == LAST_RND) begin
                        r_state <= r_state ^ w_rk_fwd;
                        r_rnd   <= LAST_RND - 4'd1;
                        r_fsm   <= ROUND;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                ROUND: begin
                    if (!r_mode) begin
                        r_rk    <= w_rk_fwd;
                        r_state <= w_enc;
                        if (r_rnd == LAST_RND) begin
                            DONE    <= 1'b1;
                            TEXTOUT <= w_enc;
                            r_fsm   <= IDLE;
                        end else begin
                            r_rnd <= r_rnd + 4'd1;
                        end
                    end else begin
                        r_rk    <= w_rk_inv;
                        r_state <= w_dec;
                        if (r_rnd == 4'd0) begin
                            DONE    <= 1'b1;
                            TEXTOUT <= w_dec;
                            r_fsm   <= IDLE;
                        end else begin
                            r_rnd <= r_rnd - 4'd1;
                        end
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed-vector bench for aes_iter_core using FIPS-197 known answers.
module tb_aes_iter_core;

    logic         CLK;
    logic         nRST;
    logic         ENCDEC;
    logic         START;
    logic [127:0] KEY;
    logic [127:0] TEXTIN;
    logic         DONE;
    logic [127:0] TEXTOUT;

    int n_cmp;
    int n_err;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam int           ENC_LAT = 11;
    localparam int           DEC_LAT = 21;

    aes_iter_core #(.NR(10)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .ENCDEC  (ENCDEC),
        .START   (START),
        .KEY     (KEY),
        .TEXTIN  (TEXTIN),
        .DONE    (DONE),
        .TEXTOUT (TEXTOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input bit dec, input logic [127:0] k, input logic [127:0] t);
        @(negedge CLK);
        ENCDEC = dec;
        KEY    = k;
        TEXTIN = t;
        START  = 1'b1;
    endtask

    // Returns the number of negedges after the START negedge at which DONE was seen, or -1.
    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (i == 1) START = 1'b0;
            if (DONE) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nRST  = 1'b0;
        START = 1'b0;
        ENCDEC = 1'b0;
        KEY    = '0;
        TEXTIN = '0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (DONE !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b want 0", DONE);
        end
        n_cmp++;
        if (TEXTOUT !== 128'h0) begin
            n_err++; $display("FAIL reset_textout: got %h want 0", TEXTOUT);
        end
        nRST = 1'b1;
    endtask

    task automatic test_encrypt();
        int cyc;
        start_op(1'b0, K1, P1);
        wait_done(40, cyc);
        n_cmp++;
        if (cyc !== ENC_LAT) begin
            n_err++; $display("FAIL enc_latency: got %0d want %0d", cyc, ENC_LAT);
        end
        n_cmp++;
        if (TEXTOUT !== C1) begin
            n_err++; $display("FAIL enc_result: got %h want %h", TEXTOUT, C1);
        end
        @(negedge CLK);
        n_cmp++;
        if (DONE !== 1'b0) begin
            n_err++; $display("FAIL enc_done_width: got %b want 0", DONE);
        end
    endtask

    task automatic test_decrypt();
        int cyc;
        start_op(1'b1, K1, C1);
        wait_done(60, cyc);
        n_cmp++;
        if (cyc !== DEC_LAT) begin
            n_err++; $display("FAIL dec_latency: got %0d want %0d", cyc, DEC_LAT);
        end
        n_cmp++;
        if (TEXTOUT !== P1) begin
            n_err++; $display("FAIL dec_result: got %h want %h", TEXTOUT, P1);
        end
        @(negedge CLK);
        n_cmp++;
        if (DONE !== 1'b0) begin
            n_err++; $display("FAIL dec_done_width: got %b want 0", DONE);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        start_op(1'b0, K1, P1);
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (i == 1) START = 1'b0;
            if (i == 5) nRST = 1'b0;
            if (i == 6) nRST = 1'b1;
            if (i >= 6) begin
                n_cmp++;
                if (DONE !== 1'b0) begin
                    n_err++; $display("FAIL abort_no_done: cycle %0d got %b want 0", i, DONE);
                end
                n_cmp++;
                if (TEXTOUT !== 128'h0) begin
                    n_err++; $display("FAIL abort_textout: cycle %0d got %h want 0", i, TEXTOUT);
                end
            end
        end
        start_op(1'b0, K1, P1);
        wait_done(40, cyc);
        n_cmp++;
        if (cyc !== ENC_LAT) begin
            n_err++; $display("FAIL abort_restart_latency: got %0d want %0d", cyc, ENC_LAT);
        end
        n_cmp++;
        if (TEXTOUT !== C1) begin
            n_err++; $display("FAIL abort_restart_result: got %h want %h", TEXTOUT, C1);
        end
    endtask

    task automatic test_x_ignore();
        int n_done;
        n_done = 0;
        start_op(1'b0, K1, P1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                START  = 1'b0;
                ENCDEC = 1'bx;
                KEY    = 'x;
                TEXTIN = 'x;
            end
            if (i == 5) begin
                START  = 1'b1;
                ENCDEC = 1'b1;
            end
            if (i == 6) START = 1'b0;
            if (DONE) n_done++;
            n_cmp++;
            if (DONE !== (i == ENC_LAT)) begin
                n_err++; $display("FAIL xign_done: cycle %0d got %b want %b", i, DONE, (i == ENC_LAT));
            end
            if (i >= ENC_LAT) begin
                n_cmp++;
                if (TEXTOUT !== C1) begin
                    n_err++; $display("FAIL xign_textout: cycle %0d got %h want %h", i, TEXTOUT, C1);
                end
            end
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_err++; $display("FAIL xign_done_count: got %0d want 1", n_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(1'b0, 128'h0, 128'h0);
        wait_done(40, cyc);
        n_cmp++;
        if (cyc !== ENC_LAT) begin
            n_err++; $display("FAIL b2b_enc_latency: got %0d want %0d", cyc, ENC_LAT);
        end
        n_cmp++;
        if (TEXTOUT !== C0) begin
            n_err++; $display("FAIL b2b_enc_result: got %h want %h", TEXTOUT, C0);
        end
        ENCDEC = 1'b1;
        KEY    = 128'h0;
        TEXTIN = C0;
        START  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            if (i == 1) START = 1'b0;
            n_cmp++;
            if (TEXTOUT !== C0) begin
                n_err++; $display("FAIL b2b_hold: cycle %0d got %h want %h", i, TEXTOUT, C0);
            end
        end
        cyc = -1;
        for (int i = 6; i <= 60; i++) begin
            @(negedge CLK);
            if (DONE) begin
                cyc = i;
                break;
            end
        end
        n_cmp++;
        if (cyc !== DEC_LAT) begin
            n_err++; $display("FAIL b2b_dec_latency: got %0d want %0d", cyc, DEC_LAT);
        end
        n_cmp++;
        if (TEXTOUT !== 128'h0) begin
            n_err++; $display("FAIL b2b_dec_result: got %h want 0", TEXTOUT);
        end
    endtask

    task automatic test_held_start();
        int n_done;
        n_done = 0;
        start_op(1'b0, K1, P1);
        for (int i = 1; i <= 33; i++) begin
            @(negedge CLK);
            if (i == 33) START = 1'b0;
            if (DONE) n_done++;
            n_cmp++;
            if (DONE !== ((i % ENC_LAT) == 0)) begin
                n_err++; $display("FAIL held_done: cycle %0d got %b want %b", i, DONE, ((i % ENC_LAT) == 0));
            end
            if (i >= ENC_LAT) begin
                n_cmp++;
                if (TEXTOUT !== C1) begin
                    n_err++; $display("FAIL held_textout: cycle %0d got %h want %h", i, TEXTOUT, C1);
                end
            end
        end
        n_cmp++;
        if (n_done !== 3) begin
            n_err++; $display("FAIL held_done_count: got %0d want 3", n_done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_reset_abort();
        test_x_ignore();
        test_back_to_back();
        test_held_start();
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
